// File: rtl/event_timestamper.sv
// event_timestamper: records the time and polarity of qualifying input edges into a FWFT FIFO.
// Latency: the timestamp is the counter value 2 cycles after the input is first sampled; ts_valid rises 3 edges after that first sample.
// Backpressure: ts_valid/ts_ready pop side; a capture into a full FIFO with no same-cycle pop is dropped and overflow is set.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, asynchronous active-low reset
//   clear, arm                : single-cycle control pulses (clear wins over arm)
//   edge_sel                  : bit0 captures rising edges, bit1 captures falling edges
//   input_signal              : asynchronous input under measurement
//   ts_data, ts_polarity      : FIFO head (timestamp, 1 = rising)
//   ts_valid, ts_ready        : FIFO head handshake
//   event_count               : events accepted since the last arm
//   overflow                  : sticky, an event was dropped because the FIFO was full
//   busy                      : capture window open
//
// Optional build macro TS_GLITCH_FILTER_EN: inserts a 3-cycle stability filter after the
// synchronizer, which suppresses pulses shorter than 3 cycles and delays every timestamp by 3.
module event_timestamper #(
  parameter int MAX_DELAY   = 1000000000,
  parameter int MAX_EVENT   = 1000,
  parameter int DELAY_WIDTH = $clog2(MAX_DELAY),
  parameter int EVENT_WIDTH = $clog2(MAX_EVENT),
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic                   clear,
  input  logic                   arm,
  input  logic [1:0]             edge_sel,
  input  logic                   input_signal,
  output logic [DELAY_WIDTH-1:0] ts_data,
  output logic                   ts_polarity,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [EVENT_WIDTH-1:0] event_count,
  output logic                   overflow,
  output logic                   busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DELAY_WIDTH + 1;

  localparam logic [DELAY_WIDTH-1:0] LAST_TICK  = DELAY_WIDTH'(MAX_DELAY - 1);
  localparam logic [EVENT_WIDTH-1:0] LAST_EVENT = EVENT_WIDTH'(MAX_EVENT - 1);
  localparam logic [PW-1:0]          DEPTH_P    = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                   sync1, sync2, sync3;
  logic                   lvl;
  logic                   edge_det, qual;
  logic [DELAY_WIDTH-1:0] counter;
  logic                   push_req, accept, pop, full;
  logic                   last_tick, last_event;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic [PW-1:0]          wr_ptr, rd_ptr, vis_ptr;
  logic [PW-1:0]          used;

  // ---------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= input_signal;
      sync2 <= sync1;
    end
  end

`ifdef TS_GLITCH_FILTER_EN
  // The filtered level only follows sync2 once sync2 has matched its two
  // previous samples, i.e. it has been stable for 3 consecutive cycles.
  logic sync2_d1, sync2_d2, filt;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sync2_d1 <= 1'b0;
      sync2_d2 <= 1'b0;
      filt     <= 1'b0;
    end else begin
      sync2_d1 <= sync2;
      sync2_d2 <= sync2_d1;
      if ((sync2 == sync2_d1) && (sync2_d1 == sync2_d2)) begin
        filt <= sync2;
      end
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  // sync3 is the history flop of whichever level feeds edge detection.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sync3 <= 1'b0;
    end else begin
      sync3 <= lvl;
    end
  end

  assign edge_det = lvl ^ sync3;
  assign qual     = edge_det && (lvl ? edge_sel[0] : edge_sel[1]);

  // ---------------------------------------------------------------
  // Capture / FIFO admission
  // ---------------------------------------------------------------
  // An arm pulse restarts the window, so a detection in that same cycle is
  // not attributed to either the old or the new window.
  assign push_req   = (state == ARMED) && qual && !arm && !clear;
  assign used       = wr_ptr - rd_ptr;
  assign full       = (used == DEPTH_P);
  assign pop        = ts_valid && ts_ready;
  assign accept     = push_req && (!full || pop);
  assign last_tick  = (counter == LAST_TICK);
  assign last_event = (event_count == LAST_EVENT);

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (arm) begin
          state_nxt = ARMED;
        end else if (last_tick || (accept && last_event)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (arm) state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  assign busy = (state == ARMED);

  // ---------------------------------------------------------------
  // Timestamp counter, event counter, overflow flag
  // ---------------------------------------------------------------
  // The counter only advances while the window stays open, so it freezes
  // at its final value when the window closes.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      counter <= '0;
    end else if (clear || arm) begin
      counter <= '0;
    end else if ((state == ARMED) && (state_nxt == ARMED)) begin
      counter <= counter + DELAY_WIDTH'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      event_count <= '0;
    end else if (clear || arm) begin
      event_count <= '0;
    end else if (accept) begin
      event_count <= event_count + EVENT_WIDTH'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (push_req && !accept) begin
      overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Timestamp FIFO
  // ---------------------------------------------------------------
  // wr_ptr counts stored entries and drives fullness; vis_ptr trails it by
  // one cycle so a freshly written entry becomes visible on the next edge.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      vis_ptr <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      vis_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      vis_ptr <= wr_ptr;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= {lvl, counter};
    end
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign ts_valid    = (vis_ptr != rd_ptr);
  assign ts_data     = ts_valid ? head[DELAY_WIDTH-1:0] : '0;
  assign ts_polarity = ts_valid & head[DELAY_WIDTH];

endmodule

// File: tb/tb_event_timestamper.sv
`timescale 1ns/1ps
module tb_event_timestamper;

  localparam int A_DW = 7;   // MAX_DELAY 100
  localparam int A_EW = 10;  // MAX_EVENT 1000
  localparam int B_DW = 10;  // MAX_DELAY 1000
  localparam int B_EW = 3;   // MAX_EVENT 4, widened to hold the value 4

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       arm = 1'b0;
  logic [1:0] edge_sel = 2'b00;
  logic       input_signal = 1'b0;
  logic       ts_ready = 1'b0;

  logic [A_DW-1:0] a_data;
  logic            a_pol, a_vld, a_ovf, a_busy;
  logic [A_EW-1:0] a_cnt;
  logic [B_DW-1:0] b_data;
  logic            b_pol, b_vld, b_ovf, b_busy;
  logic [B_EW-1:0] b_cnt;

  event_timestamper #(
    .MAX_DELAY(100), .MAX_EVENT(1000), .DELAY_WIDTH(A_DW), .EVENT_WIDTH(A_EW), .FIFO_DEPTH(16)
  ) dut_a (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .clear(clear), .arm(arm),
    .edge_sel(edge_sel), .input_signal(input_signal),
    .ts_data(a_data), .ts_polarity(a_pol), .ts_valid(a_vld), .ts_ready(ts_ready),
    .event_count(a_cnt), .overflow(a_ovf), .busy(a_busy)
  );

  event_timestamper #(
    .MAX_DELAY(1000), .MAX_EVENT(4), .DELAY_WIDTH(B_DW), .EVENT_WIDTH(B_EW), .FIFO_DEPTH(16)
  ) dut_b (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .clear(clear), .arm(arm),
    .edge_sel(edge_sel), .input_signal(input_signal),
    .ts_data(b_data), .ts_polarity(b_pol), .ts_valid(b_vld), .ts_ready(ts_ready),
    .event_count(b_cnt), .overflow(b_ovf), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One record = a run of identical cycles: inputs applied, outputs expected.
  typedef struct {
    int         rep;
    logic       arm;
    logic [1:0] esel;
    logic       in;
    logic       rdy;
    logic       vld;
    int         data;
    logic       pol;
    int         cnt;
    logic       busy;
  } vec_t;

  vec_t tbl[15];

  int exp_ts[4];
  int exp_pol[4];
  int n_exp;
  int nb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Single rising capture (edge_sel=01), then a 1-cycle pulse with both edges enabled.
    // Window opens the cycle after row 0; counter during cycle n is n-1.
    //            rep arm  esel  in   rdy  vld  data pol  cnt busy
    tbl[0]  = '{1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 0,  1'b0, 0, 1'b0};
    tbl[1]  = '{9, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 0,  1'b0, 0, 1'b1};
    tbl[2]  = '{3, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0, 1'b1};
    tbl[3]  = '{1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1, 1'b1};
    tbl[4]  = '{1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 11, 1'b1, 1, 1'b1};
    tbl[5]  = '{5, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 11, 1'b1, 1, 1'b1};
    tbl[6]  = '{1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 11, 1'b1, 1, 1'b1};
    tbl[7]  = '{1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 0,  1'b0, 1, 1'b1};
    tbl[8]  = '{3, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 0,  1'b0, 1, 1'b1};
    tbl[9]  = '{1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1, 1'b1};
    tbl[10] = '{2, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 0,  1'b0, 1, 1'b1};
    tbl[11] = '{1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 0,  1'b0, 2, 1'b1};
    tbl[12] = '{1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 26, 1'b1, 3, 1'b1};
    tbl[13] = '{1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 27, 1'b0, 3, 1'b1};
    tbl[14] = '{1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 0,  1'b0, 3, 1'b1};

    // ---------------- reset ----------------
    repeat (3) tick();
    chk("reset a.ts_valid", a_vld, 0);
    chk("reset a.ts_data", a_data, 0);
    chk("reset a.ts_polarity", a_pol, 0);
    chk("reset a.event_count", a_cnt, 0);
    chk("reset a.overflow", a_ovf, 0);
    chk("reset a.busy", a_busy, 0);
    chk("reset b.busy", b_busy, 0);
    chk("reset b.ts_valid", b_vld, 0);
    rst_n = 1'b1;
    tick();

    // ---------------- table ----------------
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        arm = tbl[r].arm;
        edge_sel = tbl[r].esel;
        input_signal = tbl[r].in;
        ts_ready = tbl[r].rdy;
        chk($sformatf("row%0d.%0d busy", r, k), a_busy, tbl[r].busy);
        chk($sformatf("row%0d.%0d event_count", r, k), a_cnt, tbl[r].cnt);
        chk($sformatf("row%0d.%0d ts_valid", r, k), a_vld, tbl[r].vld);
        chk($sformatf("row%0d.%0d overflow", r, k), a_ovf, 0);
        if (tbl[r].vld) begin
          chk($sformatf("row%0d.%0d ts_data", r, k), a_data, tbl[r].data);
          chk($sformatf("row%0d.%0d ts_polarity", r, k), a_pol, tbl[r].pol);
        end
        tick();
      end
    end
    arm = 1'b0;

    // ---------------- overflow: 20 edges into a 16-deep FIFO ----------------
    clear = 1'b1; tick(); clear = 1'b0;
    ts_ready = 1'b0; edge_sel = 2'b11; input_signal = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      input_signal = ~input_signal;
      tick(); tick();
    end
    repeat (5) tick();
    chk("ovf event_count", a_cnt, 16);
    chk("ovf overflow", a_ovf, 1);
    chk("ovf ts_valid", a_vld, 1);
    chk("ovf head ts_data", a_data, 2);
    chk("ovf head ts_polarity", a_pol, 1);
    chk("ovf busy", a_busy, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("after clear ts_valid", a_vld, 0);
    chk("after clear overflow", a_ovf, 0);
    chk("after clear busy", a_busy, 0);
    chk("after clear event_count", a_cnt, 0);

    // ---------------- window timeout (MAX_DELAY=100) ----------------
    ts_ready = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (99) tick();
    chk("timeout busy at cycle 100", a_busy, 1);
    tick();
    chk("timeout busy at cycle 101", a_busy, 0);
    input_signal = 1'b1;
    repeat (6) tick();
    chk("done edge ts_valid", a_vld, 0);
    chk("done edge event_count", a_cnt, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm busy", a_busy, 1);
    chk("rearm event_count", a_cnt, 0);

    // ---------------- MAX_EVENT=4 on dut_b ----------------
    clear = 1'b1; tick(); clear = 1'b0;
    edge_sel = 2'b11; ts_ready = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    nb = 0;
    for (int t = 1; t <= 20; t++) begin
      if ((t % 2 == 1) && (t <= 11)) input_signal = ~input_signal;
      if (t == 9) begin
        chk("maxev b.event_count before 4th", b_cnt, 3);
        chk("maxev b.busy before 4th", b_busy, 1);
      end
      if (t == 10) begin
        chk("maxev b.event_count at 4th", b_cnt, 4);
        chk("maxev b.busy at 4th", b_busy, 0);
      end
      if (b_vld) begin
        if (nb < 4) begin
          chk($sformatf("maxev entry%0d ts_data", nb), b_data, 2 + 2 * nb);
          chk($sformatf("maxev entry%0d ts_polarity", nb), b_pol, nb % 2);
        end
        nb++;
      end
      tick();
    end
    chk("maxev entries popped", nb, 4);
    chk("maxev b.event_count final", b_cnt, 4);
    chk("maxev b.overflow", b_ovf, 0);

    clear = 1'b1; arm = 1'b1; tick(); clear = 1'b0; arm = 1'b0;
    chk("clear+arm b.busy", b_busy, 0);
    chk("clear+arm a.busy", a_busy, 0);
    chk("clear+arm b.event_count", b_cnt, 0);
    tick();
    chk("clear+arm b.busy later", b_busy, 0);

    // ---------------- short pulses (filter build drops the 2-cycle one) ----------------
`ifdef TS_GLITCH_FILTER_EN
    n_exp = 2;
    exp_ts[0] = 19; exp_pol[0] = 1;
    exp_ts[1] = 22; exp_pol[1] = 0;
`else
    n_exp = 4;
    exp_ts[0] = 2;  exp_pol[0] = 1;
    exp_ts[1] = 4;  exp_pol[1] = 0;
    exp_ts[2] = 16; exp_pol[2] = 1;
    exp_ts[3] = 19; exp_pol[3] = 0;
`endif
    input_signal = 1'b0;
    repeat (8) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    ts_ready = 1'b0; edge_sel = 2'b11;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      input_signal = ((t >= 1) && (t <= 2)) || ((t >= 15) && (t <= 17));
      tick();
    end
    ts_ready = 1'b1;
    nb = 0;
    for (int t = 0; t < 8; t++) begin
      if (a_vld) begin
        if (nb < n_exp) begin
          chk($sformatf("pulse entry%0d ts_data", nb), a_data, exp_ts[nb]);
          chk($sformatf("pulse entry%0d ts_polarity", nb), a_pol, exp_pol[nb]);
        end
        nb++;
      end
      tick();
    end
    chk("pulse entry count", nb, n_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
